// File: rtl/definitions_pkg.sv
// Shared receive-path constants and the scheduler state type.
package definitions_pkg;

    localparam int OVERSAMPLE_RATE      = 16;
    localparam int HOLD_TIME            = 7;
    localparam int TIMEOUT_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO: head_data is registered and always holds the oldest entry.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic                          push_ok,
    output logic                          pop_ok,
    output logic [7:0]                    head_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign count     = count_q;
    assign head_data = head_q;

    always_comb begin
        pop_ok   = pop & ~empty;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Bypass the byte being written when it becomes the new head.
        if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/uart_rx_scheduler.sv
// Sequences the UART receiver: oversample tick, start gating, byte buffering, overrun, idle timeout.
// Define RX_SYNC_EN to put a 2-flop synchronizer between rx_pin and rx_line.
module uart_rx_scheduler
    import definitions_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          rx_pin,
    output logic                          rx_line,
    output logic                          s_tick,
    output logic                          rx_enabled,
    input  logic                          rx_busy,
    input  logic                          rx_done,
    input  logic [7:0]                    rx_data,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          rx_timeout
);

    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_LIMIT = TIMEOUT_BITS * OVERSAMPLE_RATE;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    sched_state_t     state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_max;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             done_q, busy_q, line_q;
    logic             overrun_q, overrun_d;
    logic             fired_q, fired_d;
    logic             rx_timeout_q, rx_timeout_d;
    logic             done_rise, busy_rise, line_fall;
    logic             push_req, push_ok, pop_ok;
    logic             fifo_full, fifo_empty, full_after;
    logic             tmo_clear, tmo_inc, tmo_fire;
    logic [CW-1:0]    count;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx_pin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = rx_pin;
`endif

    assign done_rise = rx_done & ~done_q;
    assign busy_rise = rx_busy & ~busy_q;
    assign line_fall = ~rx_line & line_q;
    assign push_req  = (state_q == FRAME) & done_rise;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (rd_ready),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .head_data (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign rd_valid   = ~fifo_empty;
    assign fifo_count = count;
    assign overrun    = overrun_q;
    assign rx_timeout = rx_timeout_q;

    // Baud generator; a shrinking divisor that leaves div_cnt past the end ticks and wraps.
    always_comb begin
        div_max   = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
        s_tick    = (state_q != OFF) && (div_cnt_q >= div_max);
        div_cnt_d = '0;
        if (state_q != OFF && !s_tick) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        full_after = (push_ok & ~pop_ok & (count == CW'(FIFO_DEPTH - 1)))
                   | (fifo_full & ~(pop_ok & ~push_ok));
        state_d    = state_q;
        rx_enabled = 1'b0;
        case (state_q)
            OFF: begin
                if (enable) state_d = IDLE;
            end
            IDLE: begin
                rx_enabled = 1'b1;
                if (!enable)        state_d = OFF;
                else if (busy_rise) state_d = FRAME;
                else if (fifo_full) state_d = HOLD;
            end
            FRAME: begin
                rx_enabled = 1'b1;
                if (done_rise) begin
                    if (!enable)        state_d = OFF;
                    else if (full_after) state_d = HOLD;
                    else                 state_d = IDLE;
                end
            end
            HOLD: begin
                if (!fifo_full) state_d = enable ? IDLE : OFF;
            end
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if ((push_req & fifo_full & ~pop_ok) | ((state_q == HOLD) & line_fall)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // The fired flag keeps a stalled FIFO from re-reporting until it actually moves.
    always_comb begin
        tmo_clear = push_ok | pop_ok | (state_q != IDLE);
        tmo_inc   = (state_q == IDLE) & ~fifo_empty & s_tick
                  & (tmo_cnt_q != TMO_W'(TMO_LIMIT));
        tmo_fire  = ~tmo_clear & tmo_inc & (tmo_cnt_q == TMO_W'(TMO_LIMIT - 1)) & ~fired_q;
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_clear)    tmo_cnt_d = '0;
        else if (tmo_inc) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        fired_d = fired_q;
        if (push_ok | pop_ok) fired_d = 1'b0;
        else if (tmo_fire)    fired_d = 1'b1;
        rx_timeout_d = tmo_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            div_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            line_q       <= 1'b1;
            overrun_q    <= 1'b0;
            fired_q      <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            done_q       <= rx_done;
            busy_q       <= rx_busy;
            line_q       <= rx_line;
            overrun_q    <= overrun_d;
            fired_q      <= fired_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed literal checks followed by randomized traffic against a queue-based behavioural model.
module tb_uart_rx_scheduler;

    localparam int FIFO_DEPTH   = 4;
    localparam int DIV_W        = 16;
    localparam int TIMEOUT_BITS = 4;
    localparam int LIMIT        = TIMEOUT_BITS * 16;
    localparam int M_OFF = 0, M_IDLE = 1, M_FRAME = 2, M_HOLD = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             rx_pin = 1'b1;
    logic             rx_line, s_tick, rx_enabled;
    logic             rx_busy = 1'b0;
    logic             rx_done = 1'b0;
    logic [7:0]       rx_data = '0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [2:0]       fifo_count;
    logic             overrun;
    logic             clr_overrun = 1'b0;
    logic             rx_timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_scheduler #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .DIV_W        (DIV_W),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_div     (cfg_div),
        .rx_pin      (rx_pin),
        .rx_line     (rx_line),
        .s_tick      (s_tick),
        .rx_enabled  (rx_enabled),
        .rx_busy     (rx_busy),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .rx_timeout  (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_busy = 1'b1;
        rx_done = 1'b0;
        tick();
        rx_busy = 1'b0;
        rx_done = 1'b1;
        rx_data = b;
        tick();
        $display("txn: byte %02h delivered, fifo_count=%0d", b, fifo_count);
    endtask

    // Behavioural model: compare what it predicts for this cycle, then advance on the
    // inputs that the next rising edge will sample.
    logic [7:0] m_q[$];
    bit m_valid = 0;
    int m_state, m_div, m_tmo;
    bit m_done_q, m_busy_q, m_line_q, m_over, m_fired, m_pulse;

    initial begin
        forever begin
            int  d, sz, nsz, nstate;
            bit  tk, dr, br, lf, full, pop, preq, pok, setov, clear;
            @(negedge clk);
            d  = (cfg_div == 0) ? 1 : int'(cfg_div);
            sz = m_q.size();
            tk = (m_state != M_OFF) && (m_div >= d - 1);
            if (m_valid) begin
                chk("mdl_s_tick", int'(s_tick), int'(tk));
                chk("mdl_rx_enabled", int'(rx_enabled),
                    int'(m_state == M_IDLE || m_state == M_FRAME));
                chk("mdl_rd_valid", int'(rd_valid), int'(sz > 0));
                chk("mdl_fifo_count", int'(fifo_count), sz);
                if (sz > 0) chk("mdl_rd_data", int'(rd_data), int'(m_q[0]));
                chk("mdl_overrun", int'(overrun), int'(m_over));
                chk("mdl_rx_timeout", int'(rx_timeout), int'(m_pulse));
                chk("mdl_rx_line", int'(rx_line), int'(rx_pin));
            end
            if (rst) begin
                m_valid = 1;
                m_q.delete();
                m_state = M_OFF; m_div = 0; m_tmo = 0;
                m_done_q = 0; m_busy_q = 0; m_line_q = 1;
                m_over = 0; m_fired = 0; m_pulse = 0;
            end else if (m_valid) begin
                dr    = rx_done && !m_done_q;
                br    = rx_busy && !m_busy_q;
                lf    = !rx_pin && m_line_q;
                full  = (sz == FIFO_DEPTH);
                pop   = (sz > 0) && rd_ready;
                preq  = (m_state == M_FRAME) && dr;
                pok   = preq && (!full || pop);
                setov = (preq && full && !pop) || (m_state == M_HOLD && lf);
                nsz   = sz - int'(pop) + int'(pok);
                nstate = m_state;
                case (m_state)
                    M_OFF:   if (enable) nstate = M_IDLE;
                    M_IDLE:  if (!enable) nstate = M_OFF;
                             else if (br) nstate = M_FRAME;
                             else if (full) nstate = M_HOLD;
                    M_FRAME: if (dr) nstate = !enable ? M_OFF :
                                              (nsz == FIFO_DEPTH) ? M_HOLD : M_IDLE;
                    default: if (!full) nstate = enable ? M_IDLE : M_OFF;
                endcase
                m_pulse = 0;
                clear = pok || pop || (m_state != M_IDLE);
                if (clear) begin
                    m_tmo = 0;
                end else if (sz > 0 && tk && m_tmo < LIMIT) begin
                    m_tmo++;
                    if (m_tmo == LIMIT && !m_fired) begin
                        m_pulse = 1;
                        m_fired = 1;
                    end
                end
                if (pok || pop) m_fired = 0;
                if (setov) m_over = 1;
                else if (clr_overrun) m_over = 0;
                if (pop) void'(m_q.pop_front());
                if (pok) m_q.push_back(rx_data);
                m_div    = (m_state == M_OFF || tk) ? 0 : m_div + 1;
                m_done_q = rx_done;
                m_busy_q = rx_busy;
                m_line_q = rx_pin;
                m_state  = nstate;
            end
        end
    end

    initial begin
        int n, first, np, mode, blen;
        tick();
        tick();
        chk("rst_rx_enabled", int'(rx_enabled), 0);
        chk("rst_s_tick", int'(s_tick), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rx_timeout", int'(rx_timeout), 0);
        $display("txn: reset applied");

        rst = 1'b0;
        cfg_div = 16'd5;
        n = 0;
        repeat (10) begin tick(); n += int'(s_tick); end
        chk("ticks_while_off", n, 0);
        enable = 1'b1;
        n = 0;
        repeat (20) begin tick(); n += int'(s_tick); end
        chk("ticks_div5_20cyc", n, 4);
        cfg_div = 16'd0;
        n = 0;
        repeat (8) begin tick(); n += int'(s_tick); end
        chk("ticks_div0_8cyc", n, 8);
        $display("txn: divisor sweep done");

        cfg_div = 16'd4;
        rx_busy = 1'b1;
        rx_done = 1'b0;
        tick();
        chk("frame_before_push_valid", int'(rd_valid), 0);
        rx_busy = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'hA5;
        tick();
        chk("single_rd_valid", int'(rd_valid), 1);
        chk("single_rd_data", int'(rd_data), 8'hA5);
        chk("single_count", int'(fifo_count), 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_count", int'(fifo_count), 0);
        $display("txn: byte a5 popped");

        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        chk("fill_count", int'(fifo_count), 4);
        chk("fill_hold_rx_enabled", int'(rx_enabled), 0);
        rx_pin = 1'b0;
        tick();
        chk("hold_start_overrun", int'(overrun), 1);
        rx_pin = 1'b1;
        clr_overrun = 1'b1;
        tick();
        chk("clr_alone_overrun", int'(overrun), 0);
        rx_pin = 1'b0;
        tick();
        chk("clr_race_overrun", int'(overrun), 1);
        rx_pin = 1'b1;
        clr_overrun = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        chk("hold_release_rx_enabled", int'(rx_enabled), 1);
        chk("hold_release_rd_data", int'(rd_data), 8'h11);
        rd_ready = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b0;
        chk("drain_count", int'(fifo_count), 0);
        $display("txn: fill/hold/overrun sequence done");

        cfg_div = 16'd0;
        for (int r = 0; r < 2; r++) begin
            send_byte(r == 0 ? 8'h3C : 8'h5A);
            first = -1;
            np = 0;
            for (int i = 1; i <= 200; i++) begin
                tick();
                if (rx_timeout) begin
                    np++;
                    if (first < 0) first = i;
                end
            end
            chk("timeout_latency", first, LIMIT);
            chk("timeout_pulses", np, 1);
            $display("txn: timeout round %0d first=%0d pulses=%0d", r, first, np);
            if (r == 0) begin
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
            end
        end

        cfg_div = 16'd3;
        rx_busy = 1'b1;
        rx_done = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        chk("drop_mid_frame_rx_enabled", int'(rx_enabled), 1);
        rx_busy = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'h77;
        tick();
        chk("drop_push_count", int'(fifo_count), 2);
        chk("drop_off_rx_enabled", int'(rx_enabled), 0);
        n = 0;
        repeat (6) begin tick(); n += int'(s_tick); end
        chk("drop_ticks_stopped", n, 0);
        $display("txn: enable drop mid-frame done");

        enable = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_rx_enabled", int'(rx_enabled), 0);
        chk("midrst_s_tick", int'(s_tick), 0);
        $display("txn: mid-stream reset done");

        mode = 0;
        blen = 0;
        for (int c = 0; c < 8000; c++) begin
            if (c % 400 == 0) begin
                mode = $urandom_range(0, 3);
                cfg_div = DIV_W'($urandom_range(0, 4));
                enable = 1'b1;
                $display("txn: random phase %0d mode %0d cfg_div %0d", c / 400, mode, cfg_div);
            end
            if (rx_busy) begin
                if (blen == 0) begin
                    rx_busy = 1'b0;
                    rx_done = 1'b1;
                    rx_data = 8'($urandom);
                end else begin
                    blen--;
                end
            end else if (mode != 1 && ((rx_enabled && $urandom_range(0, 3) == 0) ||
                                       $urandom_range(0, 39) == 0)) begin
                rx_busy = 1'b1;
                rx_done = 1'b0;
                blen = $urandom_range(0, 5);
            end
            case (mode)
                0: rd_ready = ($urandom_range(0, 2) == 0);
                1: rd_ready = 1'b0;
                2: rd_ready = 1'b1;
                default: rd_ready = ($urandom_range(0, 15) == 0);
            endcase
            if ($urandom_range(0, 5) == 0) rx_pin = ~rx_pin;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            clr_overrun = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
